// File: rtl/matrix_op_sched_pkg.sv
// Shared definitions for the matrix-op scheduler.
//   MATRIX_MEM_DEPTH_BIT       : matrix-memory index width
//   MATRIX_MEM_READ_MSB_INDEX  : MSB index of a matrix entry (entry width - 1)
//   state_e                    : scheduler FSM state encoding
package matrix_op_sched_pkg;

  localparam int MATRIX_MEM_DEPTH_BIT      = 4;
  localparam int MATRIX_MEM_READ_MSB_INDEX = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WB    = 3'd4
  } state_e;

endpackage

// File: rtl/matrix_wr_arb.sv
// Write-port arbiter for the shared matrix-memory write port.
//   sched_wen_i/idx/data : scheduler writeback (only asserted in WB, wins)
//   ext_valid_i/idx/data : host load path; ext_ready_o low while scheduler writes
//   mem_wen_o/idx/data   : memory write port; idx/data hold last value when idle
module matrix_wr_arb #(
  parameter int DEPTH_BIT = 4,
  parameter int DATA_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sched_wen_i,
  input  logic [DEPTH_BIT-1:0] sched_idx_i,
  input  logic [DATA_W-1:0]    sched_data_i,
  input  logic                 ext_valid_i,
  output logic                 ext_ready_o,
  input  logic [DEPTH_BIT-1:0] ext_idx_i,
  input  logic [DATA_W-1:0]    ext_data_i,
  output logic                 mem_wen_o,
  output logic [DEPTH_BIT-1:0] mem_idx_o,
  output logic [DATA_W-1:0]    mem_data_o
);

  logic [DEPTH_BIT-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 ext_go;

  // Scheduler writes only in WB, so refusing the host there is the whole arbitration.
  assign ext_ready_o = ~sched_wen_i;
  assign ext_go      = ext_valid_i & ext_ready_o;

  always_comb begin
    idx_d  = idx_q;
    data_d = data_q;
    if (sched_wen_i) begin
      idx_d  = sched_idx_i;
      data_d = sched_data_i;
    end else if (ext_go) begin
      idx_d  = ext_idx_i;
      data_d = ext_data_i;
    end
  end

  // Hold registers keep idx/data quiet between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end

  assign mem_wen_o  = sched_wen_i | ext_go;
  assign mem_idx_o  = idx_d;
  assign mem_data_o = data_d;

endmodule

// File: rtl/matrix_op_sched.sv
// Matrix-op scheduler: accepts rd/rs1/rs2 commands, reads both sources,
// hands operands to a compute engine, waits for the result and writes it
// back through the shared memory write port (shared with a host load path).
//   cmd_*     : command handshake and indices
//   mem_rs*   : read indices / combinational read data
//   mem_wen_o, mem_rd_idx_o, mem_wr_data_o : shared write port
//   eng_*     : operand handoff; res_* : engine result
//   ext_wr_*  : host write path; busy_o, op_count_o : status
module matrix_op_sched
  import matrix_op_sched_pkg::*;
#(
  parameter int DEPTH_BIT = MATRIX_MEM_DEPTH_BIT,
  parameter int DATA_W    = MATRIX_MEM_READ_MSB_INDEX + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [DEPTH_BIT-1:0] cmd_rd_i,
  input  logic [DEPTH_BIT-1:0] cmd_rs1_i,
  input  logic [DEPTH_BIT-1:0] cmd_rs2_i,
  output logic [DEPTH_BIT-1:0] mem_rs1_idx_o,
  output logic [DEPTH_BIT-1:0] mem_rs2_idx_o,
  input  logic [DATA_W-1:0]    mem_rd_data_1_i,
  input  logic [DATA_W-1:0]    mem_rd_data_2_i,
  output logic                 mem_wen_o,
  output logic [DEPTH_BIT-1:0] mem_rd_idx_o,
  output logic [DATA_W-1:0]    mem_wr_data_o,
  output logic                 eng_valid_o,
  input  logic                 eng_ready_i,
  output logic [DATA_W-1:0]    eng_op_a_o,
  output logic [DATA_W-1:0]    eng_op_b_o,
  input  logic                 res_valid_i,
  output logic                 res_ready_o,
  input  logic [DATA_W-1:0]    res_data_i,
  input  logic                 ext_wr_valid_i,
  output logic                 ext_wr_ready_o,
  input  logic [DEPTH_BIT-1:0] ext_wr_idx_i,
  input  logic [DATA_W-1:0]    ext_wr_data_i,
  output logic                 busy_o,
  output logic [15:0]          op_count_o
);

  state_e               state_q, state_d;
  logic [DEPTH_BIT-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0]    opa_q, opb_q, res_q;
  logic [15:0]          op_cnt_q;
  logic                 sched_wen;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cmd_valid_i) state_d = ST_READ;
      ST_READ:  state_d = ST_ISSUE;
      ST_ISSUE: if (eng_ready_i) state_d = ST_WAIT;
      ST_WAIT:  if (res_valid_i) state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    cmd_ready_o = (state_q == ST_IDLE);
    eng_valid_o = (state_q == ST_ISSUE);
    res_ready_o = (state_q == ST_WAIT);
    sched_wen   = (state_q == ST_WB);
    busy_o      = (state_q != ST_IDLE);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      op_cnt_q <= '0;
    end else begin
      if (state_q == ST_IDLE && cmd_valid_i) begin
        rd_q  <= cmd_rd_i;
        rs1_q <= cmd_rs1_i;
        rs2_q <= cmd_rs2_i;
      end
      // Read data is sampled before any same-edge write lands, so a
      // concurrent host write to a source yields the old contents.
      if (state_q == ST_READ) begin
        opa_q <= mem_rd_data_1_i;
        opb_q <= mem_rd_data_2_i;
      end
      if (state_q == ST_WAIT && res_valid_i) res_q <= res_data_i;
      if (state_q == ST_WB) op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  // Read indices follow the latched sources in every state.
  assign mem_rs1_idx_o = rs1_q;
  assign mem_rs2_idx_o = rs2_q;
  assign eng_op_a_o    = opa_q;
  assign eng_op_b_o    = opb_q;
  assign op_count_o    = op_cnt_q;

  matrix_wr_arb #(.DEPTH_BIT(DEPTH_BIT), .DATA_W(DATA_W)) u_wr_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .sched_wen_i  (sched_wen),
    .sched_idx_i  (rd_q),
    .sched_data_i (res_q),
    .ext_valid_i  (ext_wr_valid_i),
    .ext_ready_o  (ext_wr_ready_o),
    .ext_idx_i    (ext_wr_idx_i),
    .ext_data_i   (ext_wr_data_i),
    .mem_wen_o    (mem_wen_o),
    .mem_idx_o    (mem_rd_idx_o),
    .mem_data_o   (mem_wr_data_o)
  );

endmodule
